// File: rtl/svc_rv_mem_arb_pkg.sv
// Shared types for the svc_rv memory arbiter: request owner and in-flight read tag.
package svc_rv_mem_arb_pkg;

  localparam int MAX_MEM_LATENCY = 4;
  localparam int STARVE_W        = 4;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWNER_I};

endpackage

// File: rtl/svc_rv_mem_arb_if.sv
// Bundle of imem, dmem and unified-memory signals around the arbiter.
// Handshake: a request transfers in the cycle where req && gnt; gnt is combinational,
// and a requester holds req plus its payload stable until it sees gnt.
interface svc_rv_mem_arb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  localparam int SW = XLEN / 8;

  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic            i_gnt;
  logic            i_rvalid;
  logic [XLEN-1:0] i_rdata;

  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [SW-1:0]   d_wstrb;
  logic            d_gnt;
  logic            d_rvalid;
  logic [XLEN-1:0] d_rdata;

  logic            m_ren;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic [XLEN-1:0] m_rdata;

  // Core ports and the memory model together form the outside world of the arbiter.
  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_ren, m_we, m_addr, m_wdata, m_wstrb,
    output m_rdata
  );

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata,
    output m_ren, m_we, m_addr, m_wdata, m_wstrb,
    input  m_rdata
  );

endinterface

// File: rtl/svc_rv_mem_arb_tagq.sv
// Fixed-depth shift register of read tags; the head lines up with memory read data.
module svc_rv_mem_arb_tagq
  import svc_rv_mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  input  tag_t push,
  output tag_t head
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY) begin : g_bad_latency
    $error("svc_rv_mem_arb_tagq: MEM_LATENCY out of range 1..4");
  end

  tag_t stage_q [MEM_LATENCY];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < MEM_LATENCY; s++) stage_q[s] <= TAG_IDLE;
    end else begin
      stage_q[0] <= push;
      for (int s = 1; s < MEM_LATENCY; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign head = stage_q[MEM_LATENCY-1];

endmodule

// File: rtl/svc_rv_mem_arb.sv
// Shares one single-port memory between svc_rv imem (read-only) and dmem (read/write).
// Optional imem anti-starvation counter enabled by defining SVC_RV_MEM_ARB_STARVE_EN.
module svc_rv_mem_arb
  import svc_rv_mem_arb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int AW           = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clock,
  input logic             reset,
  svc_rv_mem_arb_if.slave bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("svc_rv_mem_arb: STARVE_LIMIT out of range 1..15");
  end

  logic            i_win;
  logic            d_win;
  logic            starve_hit;
  logic            ren_mux;
  logic            we_mux;
  logic [AW-1:0]   addr_mux;
  logic [XLEN-1:0] wdata_mux;
  logic [XLEN/8-1:0] wstrb_mux;
  tag_t            push_tag;
  tag_t            head_tag;

`ifdef SVC_RV_MEM_ARB_STARVE_EN
  logic [STARVE_W-1:0] starve_q;

  // Counts dmem wins while imem is waiting; reaching the limit hands one cycle to imem.
  assign starve_hit = bus.i_req && (starve_q == STARVE_W'(STARVE_LIMIT));

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else if (!bus.i_req || i_win) begin
      starve_q <= '0;
    end else if (d_win) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    d_win = 1'b0;
    i_win = 1'b0;
    if (!reset) begin
      if (bus.d_req && !starve_hit) d_win = 1'b1;
      else if (bus.i_req)           i_win = 1'b1;
    end
  end

  assign bus.i_gnt = i_win;
  assign bus.d_gnt = d_win;

  always_comb begin
    ren_mux   = 1'b0;
    we_mux    = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    wstrb_mux = '0;
    if (d_win) begin
      ren_mux   = !bus.d_we;
      we_mux    = bus.d_we;
      addr_mux  = bus.d_addr;
      wdata_mux = bus.d_wdata;
      wstrb_mux = bus.d_we ? bus.d_wstrb : '0;
    end else if (i_win) begin
      ren_mux  = 1'b1;
      addr_mux = bus.i_addr;
    end
  end

  assign bus.m_ren   = ren_mux;
  assign bus.m_we    = we_mux;
  assign bus.m_addr  = addr_mux;
  assign bus.m_wdata = wdata_mux;
  assign bus.m_wstrb = wstrb_mux;

  // Writes and idle cycles push an invalid tag so the head stays aligned with m_rdata.
  assign push_tag = '{valid: ren_mux, owner: (d_win ? OWNER_D : OWNER_I)};

  svc_rv_mem_arb_tagq #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_tagq (
    .clock(clock),
    .reset(reset),
    .push (push_tag),
    .head (head_tag)
  );

  always_comb begin
    bus.i_rvalid = 1'b0;
    bus.i_rdata  = '0;
    bus.d_rvalid = 1'b0;
    bus.d_rdata  = '0;
    if (!reset && head_tag.valid) begin
      if (head_tag.owner == OWNER_D) begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = bus.m_rdata;
      end else begin
        bus.i_rvalid = 1'b1;
        bus.i_rdata  = bus.m_rdata;
      end
    end
  end

`ifdef FORMAL
  a_i_stable: assert property (@(posedge clock) disable iff (reset)
    (bus.i_req && !bus.i_gnt) |=> (bus.i_req && $stable(bus.i_addr)));
  a_d_stable: assert property (@(posedge clock) disable iff (reset)
    (bus.d_req && !bus.d_gnt) |=> (bus.d_req && $stable(bus.d_we) && $stable(bus.d_addr)
                                   && $stable(bus.d_wdata) && $stable(bus.d_wstrb)));
`endif

endmodule
